// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry circular buffer of {ex, inst, pc} packets.
// Optional feature macro IFQ_BYPASS_EN: zero-latency bypass when the queue is empty.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int BUS_WD = 65
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fs_to_q_valid,
    input  logic [BUS_WD-1:0]          fs_to_q_bus,
    output logic                       q_allowin,
    output logic                       q_to_ds_valid,
    output logic [BUS_WD-1:0]          q_to_ds_bus,
    input  logic                       ds_allowin,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);

    logic [BUS_WD-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              ex_hold_q, ex_hold_d;
    logic              empty, full, accept, push, pop;
`ifdef IFQ_BYPASS_EN
    logic              byp;
`endif

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        // Deliberately independent of ds_allowin: a full queue refuses even while popping.
        q_allowin = ~full & ~ex_hold_q;
        accept    = fs_to_q_valid & q_allowin & ~flush;
        pop       = ~empty & ~flush & ds_allowin;
`ifdef IFQ_BYPASS_EN
        byp           = resetn & empty & fs_to_q_valid & ~ex_hold_q & ~flush;
        q_to_ds_valid = (~empty & ~flush) | byp;
        q_to_ds_bus   = byp ? fs_to_q_bus : mem_q[rd_ptr_q[AW-1:0]];
        // A bypassed packet taken by ID in the same cycle is never stored.
        push          = accept & ~(byp & ds_allowin);
`else
        q_to_ds_valid = ~empty & ~flush;
        q_to_ds_bus   = mem_q[rd_ptr_q[AW-1:0]];
        push          = accept;
`endif
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        // Nothing fetched after a faulting PC may enter, until the pipe is redirected.
        ex_hold_d = ex_hold_q | (accept & fs_to_q_bus[BUS_WD-1]);
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ex_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ex_hold_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ex_hold_q <= ex_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= fs_to_q_bus;
        end
    end

    assign q_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH  = 4;
    localparam int BUS_WD = 65;

    logic              clk = 1'b0;
    logic              resetn;
    logic              fs_to_q_valid;
    logic [BUS_WD-1:0] fs_to_q_bus;
    logic              q_allowin;
    logic              q_to_ds_valid;
    logic [BUS_WD-1:0] q_to_ds_bus;
    logic              ds_allowin;
    logic              flush;
    logic [2:0]        q_count;

    if_id_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .fs_to_q_valid (fs_to_q_valid),
        .fs_to_q_bus   (fs_to_q_bus),
        .q_allowin     (q_allowin),
        .q_to_ds_valid (q_to_ds_valid),
        .q_to_ds_bus   (q_to_ds_bus),
        .ds_allowin    (ds_allowin),
        .flush         (flush),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [BUS_WD-1:0] mdl_q[$];
    bit                mdl_hold;

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [BUS_WD-1:0] pkt(input bit ex, input logic [31:0] pc);
        logic [31:0] inst;
        inst = $urandom;
        return {ex, inst, pc};
    endfunction

    // Drives one cycle of inputs, checks outputs against the model, then advances both across the edge.
    task automatic step(input logic v, input logic [BUS_WD-1:0] b, input logic da, input logic fl);
        bit exp_allow, exp_valid, bypassed, accept;
        logic [BUS_WD-1:0] exp_bus;
        fs_to_q_valid = v;
        fs_to_q_bus   = b;
        ds_allowin    = da;
        flush         = fl;
        #3;
        exp_allow = (mdl_q.size() < DEPTH) && !mdl_hold;
        exp_valid = (mdl_q.size() > 0) && !fl;
        exp_bus   = (mdl_q.size() > 0) ? mdl_q[0] : '0;
        bypassed  = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (mdl_q.size() == 0 && v && !mdl_hold && !fl) begin
            exp_valid = 1'b1;
            exp_bus   = b;
            bypassed  = 1'b1;
        end
`endif
        chk("allowin", 96'(q_allowin), 96'(exp_allow));
        chk("valid", 96'(q_to_ds_valid), 96'(exp_valid));
        chk("count", 96'(q_count), 96'(mdl_q.size()));
        if (exp_valid) chk("bus", 96'(q_to_ds_bus), 96'(exp_bus));
        if (fl) begin
            mdl_q.delete();
            mdl_hold = 1'b0;
        end else begin
            accept = v && exp_allow;
            if (exp_valid && da && !bypassed) void'(mdl_q.pop_front());
            if (accept && !(bypassed && da)) mdl_q.push_back(b);
            if (accept && b[BUS_WD-1]) mdl_hold = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        fs_to_q_valid = 1'b1;
        fs_to_q_bus   = pkt(1'b0, 32'h1c00_0100);
        ds_allowin    = 1'b1;
        flush         = 1'b0;
        #1;
        chk("rst_count", 96'(q_count), 96'd0);
        chk("rst_valid", 96'(q_to_ds_valid), 96'd0);
        chk("rst_allowin", 96'(q_allowin), 96'd1);
        fs_to_q_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mdl_q.delete();
        mdl_hold = 1'b0;
    endtask

    initial begin
        logic [BUS_WD-1:0] p;
        resetn        = 1'b0;
        fs_to_q_valid = 1'b0;
        fs_to_q_bus   = '0;
        ds_allowin    = 1'b0;
        flush         = 1'b0;
        mdl_hold      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Fill with ID stalled; fifth packet must be held off.
        for (int i = 0; i < 5; i++) step(1'b1, pkt(1'b0, 32'h1c00_0000 + 32'(4 * i)), 1'b0, 1'b0);
        chk("t1_count_full", 96'(q_count), 96'd4);
        chk("t1_allowin_full", 96'(q_allowin), 96'd0);

        // Full queue pops but does not push in the same cycle.
        p = pkt(1'b0, 32'h1c00_0010);
        step(1'b1, p, 1'b1, 1'b0);
        chk("t2_count", 96'(q_count), 96'd3);
        step(1'b1, p, 1'b0, 1'b0);
        chk("t2_refill", 96'(q_count), 96'd4);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush with 3 held and IF still valid.
        step(1'b1, pkt(1'b0, 32'h1c00_0020), 1'b1, 1'b1);
        chk("t4_count", 96'(q_count), 96'd0);

        // Exception packet closes the door until a flush.
        step(1'b1, pkt(1'b1, 32'h1c00_0002), 1'b0, 1'b0);
        chk("t5_hold", 96'(q_allowin), 96'd0);
        step(1'b1, pkt(1'b0, 32'h1c00_0006), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_still_hold", 96'(q_allowin), 96'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_release", 96'(q_allowin), 96'd1);

`ifdef IFQ_BYPASS_EN
        step(1'b1, pkt(1'b0, 32'h1c00_0010), 1'b1, 1'b0);
        chk("t6_count", 96'(q_count), 96'd0);
`endif

        // Ordered stream with toggling ID stall.
        for (int i = 0; i < 20; i++) step(i < 10, pkt(1'b0, 32'h1c00_1000 + 32'(4 * i)), i[0], 1'b0);

        // Random traffic with a mid-stream reset.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step($urandom_range(0, 3) != 0,
                 pkt($urandom_range(0, 15) == 0, $urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
